ex_muldiv: RTL

Execute-stage multiply/divide unit for the 32-bit MIPS pipeline. It consumes the decoded `aluop` and the forwarded operand values that the decode stage hands to execute. It produces HI/LO write-back data and a pipeline stall request. Single-cycle MULT/MULTU, two-cycle MADD/MADDU/MSUB/MSUBU accumulate, and an iterative 32-step DIV/DIVU live here; the rest of execute stays combinational.

---
 rtl/ex_muldiv.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage MULT/MULTU, MADD/MSUB accumulate and iterative DIV/DIVU.
// Build option: define MULDIV_DIV_EN to include the 32-step restoring divider.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b10101000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;

  logic        is_mult, is_mac, mac_sub, prod_signed;
  logic [63:0] prod, mac_sum;
  logic        mac_phase_q, mac_phase_d;
  logic [63:0] mac_temp_q, mac_temp_d;
  logic        div_stall, div_wr;
  logic [31:0] div_quot, div_rem;

  assign is_mult     = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
  assign is_mac      = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                       (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign mac_sub     = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign prod_signed = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MADD_OP) ||
                       (aluop_i == EXE_MSUB_OP);

  assign prod = prod_signed ? ({{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i})
                            : ({32'd0, reg1_i} * {32'd0, reg2_i});
  assign mac_sum = mac_sub ? ({hi_i, lo_i} - mac_temp_q) : ({hi_i, lo_i} + mac_temp_q);

  // Accumulate ops: phase 0 registers the product, phase 1 folds in the live HI/LO.
  always_comb begin
    mac_phase_d = 1'b0;
    mac_temp_d  = mac_temp_q;
    if (!flush_i && is_mac) begin
      if (!mac_phase_q) begin
        mac_temp_d  = prod;
        mac_phase_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_phase_q <= 1'b0;
      mac_temp_q  <= 64'd0;
    end else begin
      mac_phase_q <= mac_phase_d;
      mac_temp_q  <= mac_temp_d;
    end
  end

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_e;

  div_state_e  div_state_q, div_state_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [64:0] div_sr_q, div_sr_d, div_sh;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic        is_div, div_signed;

  assign is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign div_signed = (aluop_i == EXE_DIV_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_state_q <= DIV_FREE;
      div_cnt_q   <= 6'd0;
      div_sr_q    <= 65'd0;
      divisor_q   <= 32'd0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_sr_q    <= div_sr_d;
      divisor_q   <= divisor_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

  // Shift register holds remainder in [64:32] and the developing quotient in [31:0].
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_sr_d    = div_sr_q;
    divisor_d   = divisor_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    div_sh      = div_sr_q << 1;
    if (flush_i) begin
      div_state_d = DIV_FREE;
    end else begin
      case (div_state_q)
        DIV_FREE: begin
          if (is_div) begin
            if (reg2_i == 32'd0) begin
              div_state_d = DIV_BYZERO;
            end else begin
              div_sr_d    = {33'd0, (div_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i};
              divisor_d   = (div_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;
              neg_quot_d  = div_signed && (reg1_i[31] ^ reg2_i[31]);
              neg_rem_d   = div_signed && reg1_i[31];
              div_cnt_d   = 6'd0;
              div_state_d = DIV_ON;
            end
          end
        end
        DIV_BYZERO: begin
          div_sr_d    = 65'd0;
          neg_quot_d  = 1'b0;
          neg_rem_d   = 1'b0;
          div_state_d = DIV_END;
        end
        DIV_ON: begin
          div_sr_d = div_sh;
          if (div_sh[64:32] >= {1'b0, divisor_q}) begin
            div_sr_d[64:32] = div_sh[64:32] - {1'b0, divisor_q};
            div_sr_d[0]     = 1'b1;
          end
          div_cnt_d = div_cnt_q + 6'd1;
          if (div_cnt_q == 6'd31) div_state_d = DIV_END;
        end
        DIV_END:  div_state_d = DIV_FREE;
        default:  div_state_d = DIV_FREE;
      endcase
    end
  end

  always_comb begin
    div_quot  = neg_quot_q ? (32'd0 - div_sr_q[31:0]) : div_sr_q[31:0];
    div_rem   = neg_rem_q ? (32'd0 - div_sr_q[63:32]) : div_sr_q[63:32];
    div_stall = ((div_state_q == DIV_FREE) && is_div) ||
                (div_state_q == DIV_BYZERO) || (div_state_q == DIV_ON);
    div_wr    = (div_state_q == DIV_END);
  end
`else
  assign div_stall = 1'b0;
  assign div_wr    = 1'b0;
  assign div_quot  = 32'd0;
  assign div_rem   = 32'd0;
`endif

  // stallreq_o=1 asks ctrl to hold IF/ID/EX so aluop_i stays put; whilo_o qualifies hi_o/lo_o.
  always_comb begin
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    stallreq_o = 1'b0;
    if (!rst && !flush_i) begin
      if (div_wr) begin
        whilo_o = 1'b1;
        hi_o    = div_rem;
        lo_o    = div_quot;
      end else if (div_stall) begin
        stallreq_o = 1'b1;
      end else if (is_mult) begin
        whilo_o      = 1'b1;
        {hi_o, lo_o} = prod;
      end else if (is_mac) begin
        if (!mac_phase_q) begin
          stallreq_o = 1'b1;
        end else begin
          whilo_o      = 1'b1;
          {hi_o, lo_o} = mac_sum;
        end
      end
    end
  end

endmodule
